// File: rtl/rast_line_gen.sv
// Bresenham line rasterizer: walks one segment per command and pushes visible
// pixels into the rasterizer-to-framebuffer-writer FIFO, one step per cycle.
module rast_line_gen #(
    parameter int RAST_FBW_FIFO_LEN = 64,
    parameter int LINE_LEN          = 9,
    parameter int COL_LEN           = 10,
    parameter int LINE_MAX          = 480,
    parameter int COL_MAX           = 640
) (
    input  logic                         Bus2IP_Clk,
    input  logic                         Bus2IP_Resetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [COL_LEN-1:0]           cmd_x0,
    input  logic [COL_LEN-1:0]           cmd_x1,
    input  logic [LINE_LEN-1:0]          cmd_y0,
    input  logic [LINE_LEN-1:0]          cmd_y1,
    input  logic [31:0]                  cmd_color,
    output logic [0:RAST_FBW_FIFO_LEN-1] fifo_Dout,
    output logic                         fifo_wr_en,
    input  logic                         fifo_full,
    output logic                         busy,
    output logic                         line_done
);

    localparam int DW   = COL_LEN + 2;
    localparam int PADW = RAST_FBW_FIFO_LEN - LINE_LEN - COL_LEN - 32;

    localparam logic [COL_LEN:0]    COL_LIM  = (COL_LEN + 1)'(COL_MAX);
    localparam logic [LINE_LEN:0]   LINE_LIM = (LINE_LEN + 1)'(LINE_MAX);
    localparam logic [COL_LEN-1:0]  X_ONE    = COL_LEN'(1);
    localparam logic [LINE_LEN-1:0] Y_ONE    = LINE_LEN'(1);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_* are ignored in every other cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [COL_LEN-1:0]  x0_q, x1_q, x_q;
    logic [LINE_LEN-1:0] y0_q, y1_q, y_q;
    logic [31:0]         color_q;
    logic signed [DW-1:0] dx_q, dy_q, err_q;
    logic                sx_pos_q, sy_pos_q;

    logic                 in_range, at_end, step_go, x_step, y_step;
    logic signed [DW-1:0] xd, yd, dx_abs, dy_neg, err_nxt;
    logic signed [DW:0]   e2, dx_ext, dy_ext;

    assign in_range = ({1'b0, x_q} < COL_LIM) && ({1'b0, y_q} < LINE_LIM);
    assign at_end   = (x_q == x1_q) && (y_q == y1_q);

    assign xd     = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
    assign yd     = $signed({{(DW - LINE_LEN){1'b0}}, y1_q})
                  - $signed({{(DW - LINE_LEN){1'b0}}, y0_q});
    assign dx_abs = xd[DW-1] ? -xd : xd;
    assign dy_neg = yd[DW-1] ? yd : -yd;

    // e2 is one bit wider than err so that doubling never overflows.
    assign e2      = {err_q, 1'b0};
    assign dx_ext  = {dx_q[DW-1], dx_q};
    assign dy_ext  = {dy_q[DW-1], dy_q};
    assign x_step  = (e2 >= dy_ext);
    assign y_step  = (e2 <= dx_ext);
    assign err_nxt = err_q + (x_step ? dy_q : '0) + (y_step ? dx_q : '0);

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        fifo_wr_en = 1'b0;
        line_done  = 1'b0;
        step_go    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = Bus2IP_Resetn;
                if (cmd_valid && Bus2IP_Resetn) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STEP;
            end
            STEP: begin
                // Invisible pixels never push, so the FIFO cannot hold them up.
                if (!in_range || !fifo_full) begin
                    step_go    = 1'b1;
                    fifo_wr_en = in_range && Bus2IP_Resetn;
                    if (at_end) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                line_done = Bus2IP_Resetn;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_pos_q <= 1'b0;
            sy_pos_q <= 1'b0;
        end else begin
            if (state_q == IDLE && cmd_valid) begin
                x0_q    <= cmd_x0;
                x1_q    <= cmd_x1;
                y0_q    <= cmd_y0;
                y1_q    <= cmd_y1;
                color_q <= cmd_color;
            end
            if (state_q == SETUP) begin
                dx_q     <= dx_abs;
                dy_q     <= dy_neg;
                err_q    <= dx_abs + dy_neg;
                sx_pos_q <= (x0_q < x1_q);
                sy_pos_q <= (y0_q < y1_q);
                x_q      <= x0_q;
                y_q      <= y0_q;
            end
            if (step_go && !at_end) begin
                err_q <= err_nxt;
                if (x_step) begin
                    x_q <= sx_pos_q ? x_q + X_ONE : x_q - X_ONE;
                end
                if (y_step) begin
                    y_q <= sy_pos_q ? y_q + Y_ONE : y_q - Y_ONE;
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign fifo_Dout = {y_q, x_q, {PADW{1'b0}}, color_q};

endmodule

// File: tb/tb_rast_line_gen.sv
// Self-checking bench for rast_line_gen: directed vector table, hand-written
// stall/clip/reset sequences and randomized segments against a pixel model.
module tb_rast_line_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0, cmd_x1 = '0;
    logic [8:0]  cmd_y0 = '0, cmd_y1 = '0;
    logic [31:0] cmd_color = '0;
    logic [0:63] fifo_Dout;
    logic        fifo_wr_en;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic        line_done;

    rast_line_gen dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Resetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x0        (cmd_x0),
        .cmd_x1        (cmd_x1),
        .cmd_y0        (cmd_y0),
        .cmd_y1        (cmd_y1),
        .cmd_color     (cmd_color),
        .fifo_Dout     (fifo_Dout),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .busy          (busy),
        .line_done     (line_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // scoreboard
    logic [63:0] exp_q[$];
    logic [63:0] dout_v;
    int checks = 0;
    int failures = 0;
    int push_cnt = 0, done_cnt = 0, acc_cyc = -1, first_cyc = -1, done_cyc = -1;
    bit no_push = 1'b0;

    assign dout_v = fifo_Dout;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (no_push) begin
            chk("no_push_after_reset", 64'(fifo_wr_en), 64'd0);
        end else if (fifo_wr_en) begin
            if (fifo_full) chk("push_while_full", 64'(fifo_full), 64'd0);
            if (exp_q.size() == 0) chk("extra_push", dout_v, 64'd0);
            else chk("pixel", dout_v, exp_q.pop_front());
            if (push_cnt == 0) first_cyc = cyc;
            push_cnt++;
        end
        if (line_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // reference model: Bresenham walk on plain integers
    task automatic model(input int x0, input int y0, input int x1, input int y1,
                         input logic [31:0] c, output int steps, output int npix);
        int x, y, dx, dy, sx, sy, err, e2;
        x = x0;
        y = y0;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        npix = 0;
        exp_q.delete();
        for (int g = 0; g < 4096; g++) begin
            if (x < 640 && y < 480) begin
                exp_q.push_back({y[8:0], x[9:0], 13'b0, c});
                npix++;
            end
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        steps = ((dx > -dy) ? dx : -dy) + 1;
    endtask

    task automatic clear_counters();
        push_cnt = 0;
        done_cnt = 0;
        acc_cyc = -1;
        first_cyc = -1;
        done_cyc = -1;
    endtask

    // driver: issue one command and check its completion
    task automatic issue(input int x0, input int y0, input int x1, input int y1,
                         input logic [31:0] c);
        @(posedge clk);
        #1;
        cmd_x0 = x0[9:0];
        cmd_y0 = y0[8:0];
        cmd_x1 = x1[9:0];
        cmd_y1 = y1[8:0];
        cmd_color = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && acc_cyc < 0; i++) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 10'($urandom);
        cmd_x1 = 10'($urandom);
        cmd_y0 = 9'($urandom);
        cmd_y1 = 9'($urandom);
        cmd_color = $urandom;
        if (acc_cyc < 0) chk("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [31:0] c, input int exp_pix, input int exp_done,
                           input bit first_in);
        issue(x0, y0, x1, y1, c);
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
        @(negedge clk);
        chk("ready_after_done", 64'(cmd_ready), 64'd1);
        chk("idle_after_done", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        chk("line_done_count", 64'(done_cnt), 64'd1);
        chk("push_count", 64'(push_cnt), 64'(exp_pix));
        chk("model_drained", 64'(exp_q.size()), 64'd0);
        if (exp_done >= 0) chk("done_latency", 64'(done_cyc - acc_cyc), 64'(exp_done));
        if (exp_done >= 0 && first_in) chk("first_push_latency", 64'(first_cyc - acc_cyc), 64'd2);
    endtask

    task automatic stall_after(input int n_push, input int len);
        for (int i = 0; i < 500 && push_cnt < n_push; i++) @(posedge clk);
        #1 fifo_full = 1'b1;
        repeat (len) @(posedge clk);
        #1 fifo_full = 1'b0;
    endtask

    typedef struct {
        int x0, y0, x1, y1;
        logic [31:0] color;
        int exp_pix;
        int exp_done;
    } vec_t;

    vec_t vecs[9];
    bit   rand_en = 1'b0;

    initial begin
        int steps, npix, x0, y0, x1, y1;
        logic [31:0] c;

        vecs[0] = '{10, 5, 14, 5, 32'hFF00FF00, 5, 7};
        vecs[1] = '{0, 0, 2, 7, 32'h12345678, 8, 10};
        vecs[2] = '{3, 3, 3, 3, 32'hA5A5A5A5, 1, 3};
        vecs[3] = '{636, 479, 643, 479, 32'h000000FF, 4, 10};
        vecs[4] = '{5, 20, 5, 10, 32'hDEADBEEF, 11, 13};
        vecs[5] = '{0, 500, 3, 511, 32'h11111111, 0, 14};
        vecs[6] = '{1023, 511, 1020, 508, 32'h22222222, 0, 6};
        vecs[7] = '{20, 20, 10, 15, 32'h33333333, 11, 13};
        vecs[8] = '{630, 470, 650, 490, 32'h44444444, 10, 23};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset_wr_en", 64'(fifo_wr_en), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rel_busy", 64'(busy), 64'd0);
        chk("rel_line_done", 64'(line_done), 64'd0);
        chk("rel_dout", dout_v, 64'd0);

        // directed vector table
        foreach (vecs[i]) begin
            model(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color, steps, npix);
            clear_counters();
            run_cmd(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].color,
                    vecs[i].exp_pix, vecs[i].exp_done,
                    vecs[i].x0 < 640 && vecs[i].y0 < 480);
        end

        // backpressure: 3 full cycles after the 2nd push
        model(0, 0, 4, 0, 32'hCAFEF00D, steps, npix);
        clear_counters();
        fork
            run_cmd(0, 0, 4, 0, 32'hCAFEF00D, 5, 10, 1'b1);
            stall_after(2, 3);
        join

        // clipping: invisible steps ignore a full FIFO
        model(636, 479, 643, 479, 32'h0BADCAFE, steps, npix);
        clear_counters();
        fork
            run_cmd(636, 479, 643, 479, 32'h0BADCAFE, 4, 10, 1'b1);
            stall_after(4, 6);
        join

        // reset in the middle of a long segment
        model(0, 0, 100, 0, 32'h55AA55AA, steps, npix);
        clear_counters();
        issue(0, 0, 100, 0, 32'h55AA55AA);
        for (int i = 0; i < 200 && push_cnt < 20; i++) @(posedge clk);
        chk("pushes_before_reset", 64'(push_cnt), 64'd20);
        #1;
        rst_n = 1'b0;
        no_push = 1'b1;
        @(negedge clk);
        chk("midreset_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("midreset_line_done", 64'(line_done), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_busy", 64'(busy), 64'd0);
        chk("postreset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("postreset_dout", dout_v, 64'd0);
        repeat (3) @(posedge clk);
        no_push = 1'b0;
        model(vecs[0].x0, vecs[0].y0, vecs[0].x1, vecs[0].y1, vecs[0].color, steps, npix);
        clear_counters();
        run_cmd(vecs[0].x0, vecs[0].y0, vecs[0].x1, vecs[0].y1, vecs[0].color,
                vecs[0].exp_pix, vecs[0].exp_done, 1'b1);

        // randomized segments, no backpressure: full timing check
        for (int n = 0; n < 8; n++) begin
            x0 = $urandom_range(0, 700);
            x1 = $urandom_range(0, 700);
            y0 = $urandom_range(0, 511);
            y1 = $urandom_range(0, 511);
            c = $urandom;
            model(x0, y0, x1, y1, c, steps, npix);
            clear_counters();
            run_cmd(x0, y0, x1, y1, c, npix, steps + 2, x0 < 640 && y0 < 480);
        end

        // randomized segments with random FIFO backpressure
        rand_en = 1'b1;
        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    x0 = $urandom_range(560, 1023);
                    x1 = $urandom_range(560, 1023);
                    y0 = $urandom_range(400, 511);
                    y1 = $urandom_range(400, 511);
                    c = $urandom;
                    model(x0, y0, x1, y1, c, steps, npix);
                    clear_counters();
                    run_cmd(x0, y0, x1, y1, c, npix, -1, 1'b0);
                end
                rand_en = 1'b0;
            end
            begin
                while (rand_en) begin
                    @(posedge clk);
                    #1 fifo_full = ($urandom_range(0, 3) == 0);
                end
                fifo_full = 1'b0;
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
